// File: rtl/td4_core_if.sv
// td4_core_if: ROM fetch bus plus switch/LED board I/O for the TD4 core.
// The master side is the core; the slave side is the ROM/board model.
interface td4_core_if;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic [3:0] in_port;
  logic [3:0] out_port;
  logic       carry_o;

  modport master (
    output rom_addr,
    output out_port,
    output carry_o,
    input  rom_data,
    input  in_port
  );

  modport slave (
    input  rom_addr,
    input  out_port,
    input  carry_o,
    output rom_data,
    output in_port
  );
endinterface

// File: rtl/td4_core.sv
// td4_core: 4-bit TD4 execution core. Holds PC, registers A/B, the carry flag
// and the LED output latch, fetches from a combinational 16x8 ROM and runs one
// instruction per prescaler tick. Defining TD4_STEP_EN adds run_i/step_i
// controls that gate execution; without it the core free-runs on every tick.
module td4_core #(
  parameter int unsigned CLK_DIV = 1,
  parameter int unsigned DIV_W   = 24
) (
  input  logic clk,
  input  logic rst_n,
`ifdef TD4_STEP_EN
  input  logic run_i,
  input  logic step_i,
`endif
  td4_core_if.master bus
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;
  logic             exec;
  logic [3:0]       pc_q, pc_d;
  logic [3:0]       a_q, a_d;
  logic [3:0]       b_q, b_d;
  logic [3:0]       out_q, out_d;
  logic             c_q, c_d;
  logic [3:0]       in_meta_q, in_meta_d;
  logic [3:0]       in_sync_q, in_sync_d;
  logic [3:0]       op, im;
  logic [4:0]       sum_a, sum_b;

  assign op    = bus.rom_data[7:4];
  assign im    = bus.rom_data[3:0];
  assign sum_a = {1'b0, a_q} + {1'b0, im};
  assign sum_b = {1'b0, b_q} + {1'b0, im};

  // Prescaler: count 0..CLK_DIV-1, tick on the last count, then wrap.
  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + DIV_W'(1);
  end

  // Two-flop synchronizer for the switch inputs.
  always_comb begin
    in_meta_d = bus.in_port;
    in_sync_d = in_meta_q;
  end

`ifdef TD4_STEP_EN
  logic run_meta_q, run_meta_d, run_sync_q, run_sync_d;
  logic step_meta_q, step_meta_d, step_sync_q, step_sync_d;
  logic step_prev_q, step_prev_d;
  logic step_pend_q, step_pend_d;
  logic step_rise;

  // Run/step control: synchronize, edge-detect step, keep a 1-deep pending flag.
  // A pending step is consumed on the next tick; edges arriving while one is
  // pending are dropped, but an edge on the consuming cycle re-arms the flag.
  always_comb begin
    run_meta_d  = run_i;
    run_sync_d  = run_meta_q;
    step_meta_d = step_i;
    step_sync_d = step_meta_q;
    step_prev_d = step_sync_q;
    step_rise   = step_sync_q & ~step_prev_q;
    step_pend_d = (step_pend_q & ~tick) | step_rise;
    exec        = tick & (run_sync_q | step_pend_q);
  end

  // Control flops for run/step; cleared asynchronously with the core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_meta_q  <= 1'b0;
      run_sync_q  <= 1'b0;
      step_meta_q <= 1'b0;
      step_sync_q <= 1'b0;
      step_prev_q <= 1'b0;
      step_pend_q <= 1'b0;
    end else begin
      run_meta_q  <= run_meta_d;
      run_sync_q  <= run_sync_d;
      step_meta_q <= step_meta_d;
      step_sync_q <= step_sync_d;
      step_prev_q <= step_prev_d;
      step_pend_q <= step_pend_d;
    end
  end
`else
  assign exec = tick;
`endif

  // Instruction decode/execute: next architectural state for this fetch.
  // Carry is cleared by every executed instruction except ADD; JNC reads the
  // carry held before its own tick.
  always_comb begin
    pc_d  = pc_q;
    a_d   = a_q;
    b_d   = b_q;
    c_d   = c_q;
    out_d = out_q;
    if (exec) begin
      pc_d = pc_q + 4'd1;
      c_d  = 1'b0;
      case (op)
        4'b0000: {c_d, a_d} = sum_a;
        4'b0001: a_d = b_q;
        4'b0010: a_d = in_sync_q;
        4'b0011: a_d = im;
        4'b0100: b_d = a_q;
        4'b0101: {c_d, b_d} = sum_b;
        4'b0110: b_d = in_sync_q;
        4'b0111: b_d = im;
        4'b1001: out_d = b_q;
        4'b1011: out_d = im;
        4'b1110: if (!c_q) pc_d = im;
        4'b1111: pc_d = im;
        default: ;
      endcase
    end
  end

  // Architectural state, prescaler and synchronizer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      pc_q      <= 4'd0;
      a_q       <= 4'd0;
      b_q       <= 4'd0;
      c_q       <= 1'b0;
      out_q     <= 4'd0;
      in_meta_q <= 4'd0;
      in_sync_q <= 4'd0;
    end else begin
      div_q     <= div_d;
      pc_q      <= pc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      out_q     <= out_d;
      in_meta_q <= in_meta_d;
      in_sync_q <= in_sync_d;
    end
  end

  assign bus.rom_addr = pc_q;
  assign bus.out_port = out_q;
  assign bus.carry_o  = c_q;

endmodule
